// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode results, inserts bubbles on stall/flush.
// Optional PIPE_STATS_EN adds saturating stall/flush event counters.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    input  logic [4:0]        Rw_ID,
    input  logic [DATA_W-1:0] busA_ID,
    input  logic [DATA_W-1:0] busB_ID,
    input  logic [DATA_W-1:0] imm_ID,
    input  logic [PC_W-1:0]   PC_ID,
    input  logic              ALU_SRC_ID,
    input  logic              LD_ID,
    input  logic              REG_WR_ID,
    input  logic              MEM_WR_ID,
    input  logic              BRANCH_ID,
    input  logic [3:0]        ALU_CTRL_ID,
    input  logic              Stall_ID,
    input  logic [1:0]        OP_A_SEL,
    input  logic [1:0]        OP_B_SEL,
    input  logic              Flush_EX,
    output logic [DATA_W-1:0] busA_EX,
    output logic [DATA_W-1:0] busB_EX,
    output logic [DATA_W-1:0] imm_EX,
    output logic [PC_W-1:0]   PC_EX,
    output logic              ALU_SRC_EX,
    output logic              MEM_WR_EX,
    output logic              BRANCH_EX,
    output logic              REG_WR_EX,
    output logic [3:0]        ALU_CTRL_EX,
    output logic [1:0]        OP_A_SEL_EX,
    output logic [1:0]        OP_B_SEL_EX,
    output logic [4:0]        Rw_ID_EX,
    output logic              LD_ID_EX,
    output logic [4:0]        Rw_EX_MEM,
    output logic              LD_EX_MEM,
    output logic              valid_EX
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    logic [DATA_W-1:0] r_busA, r_busB, r_imm;
    logic [PC_W-1:0]   r_pc;
    logic              r_alu_src, r_mem_wr, r_branch, r_reg_wr;
    logic [3:0]        r_alu_ctrl;
    logic [1:0]        r_opa, r_opb;
    logic [4:0]        r_rw_ex, r_rw_mem;
    logic              r_ld_ex, r_ld_mem, r_valid;
    logic              w_bubble;

    assign w_bubble = Flush_EX | Stall_ID;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busA     <= '0;
            r_busB     <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_alu_src  <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_branch   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_alu_ctrl <= '0;
            r_opa      <= 2'b00;
            r_opb      <= 2'b00;
            r_rw_ex    <= '0;
            r_ld_ex    <= 1'b0;
            r_rw_mem   <= '0;
            r_ld_mem   <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            // EX never stalls, so the MEM tag always follows the EX tag
            r_rw_mem <= r_rw_ex;
            r_ld_mem <= r_ld_ex;
            if (w_bubble) begin
                r_busA     <= '0;
                r_busB     <= '0;
                r_imm      <= '0;
                r_pc       <= '0;
                r_alu_src  <= 1'b0;
                r_mem_wr   <= 1'b0;
                r_branch   <= 1'b0;
                r_reg_wr   <= 1'b0;
                r_alu_ctrl <= '0;
                r_opa      <= 2'b00;
                r_opb      <= 2'b00;
                r_rw_ex    <= '0;
                r_ld_ex    <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_busA     <= busA_ID;
                r_busB     <= busB_ID;
                r_imm      <= imm_ID;
                r_pc       <= PC_ID;
                r_alu_src  <= ALU_SRC_ID;
                r_mem_wr   <= MEM_WR_ID;
                r_branch   <= BRANCH_ID;
                r_reg_wr   <= REG_WR_ID;
                r_alu_ctrl <= ALU_CTRL_ID;
                r_opa      <= OP_A_SEL;
                r_opb      <= OP_B_SEL;
                r_rw_ex    <= REG_WR_ID ? Rw_ID : 5'd0;
                r_ld_ex    <= LD_ID;
                r_valid    <= 1'b1;
            end
        end
    end

    assign busA_EX     = r_busA;
    assign busB_EX     = r_busB;
    assign imm_EX      = r_imm;
    assign PC_EX       = r_pc;
    assign ALU_SRC_EX  = r_alu_src;
    assign MEM_WR_EX   = r_mem_wr;
    assign BRANCH_EX   = r_branch;
    assign REG_WR_EX   = r_reg_wr;
    assign ALU_CTRL_EX = r_alu_ctrl;
    assign OP_A_SEL_EX = r_opa;
    assign OP_B_SEL_EX = r_opb;
    assign Rw_ID_EX    = r_rw_ex;
    assign LD_ID_EX    = r_ld_ex;
    assign Rw_EX_MEM   = r_rw_mem;
    assign LD_EX_MEM   = r_ld_mem;
    assign valid_EX    = r_valid;

`ifdef PIPE_STATS_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (Flush_EX) begin
            if (r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (Stall_ID) begin
            if (r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    // $0 always reads zero, so forwarding into it is a hazard-unit bug
    a_rs_nofwd: assert property (@(posedge clk) disable iff (reset)
        (Rs_ID == 5'd0) |-> (OP_A_SEL == 2'b00));
    a_rt_nofwd: assert property (@(posedge clk) disable iff (reset)
        (Rt_ID == 5'd0) |-> (OP_B_SEL == 2'b00));

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table plus randomized tag-tracking run.
// Counter checks are active when PIPE_STATS_EN is defined.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs_ID, Rt_ID, Rw_ID;
    logic [31:0] busA_ID, busB_ID, imm_ID, PC_ID;
    logic        ALU_SRC_ID, LD_ID, REG_WR_ID, MEM_WR_ID, BRANCH_ID;
    logic [3:0]  ALU_CTRL_ID;
    logic        Stall_ID, Flush_EX;
    logic [1:0]  OP_A_SEL, OP_B_SEL;
    logic [31:0] busA_EX, busB_EX, imm_EX, PC_EX;
    logic        ALU_SRC_EX, MEM_WR_EX, BRANCH_EX, REG_WR_EX;
    logic [3:0]  ALU_CTRL_EX;
    logic [1:0]  OP_A_SEL_EX, OP_B_SEL_EX;
    logic [4:0]  Rw_ID_EX, Rw_EX_MEM;
    logic        LD_ID_EX, LD_EX_MEM, valid_EX;
`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .reset(reset),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rw_ID(Rw_ID),
        .busA_ID(busA_ID), .busB_ID(busB_ID),
        .imm_ID(imm_ID), .PC_ID(PC_ID),
        .ALU_SRC_ID(ALU_SRC_ID), .LD_ID(LD_ID),
        .REG_WR_ID(REG_WR_ID), .MEM_WR_ID(MEM_WR_ID),
        .BRANCH_ID(BRANCH_ID), .ALU_CTRL_ID(ALU_CTRL_ID),
        .Stall_ID(Stall_ID), .OP_A_SEL(OP_A_SEL),
        .OP_B_SEL(OP_B_SEL), .Flush_EX(Flush_EX),
        .busA_EX(busA_EX), .busB_EX(busB_EX),
        .imm_EX(imm_EX), .PC_EX(PC_EX),
        .ALU_SRC_EX(ALU_SRC_EX), .MEM_WR_EX(MEM_WR_EX),
        .BRANCH_EX(BRANCH_EX), .REG_WR_EX(REG_WR_EX),
        .ALU_CTRL_EX(ALU_CTRL_EX),
        .OP_A_SEL_EX(OP_A_SEL_EX), .OP_B_SEL_EX(OP_B_SEL_EX),
        .Rw_ID_EX(Rw_ID_EX), .LD_ID_EX(LD_ID_EX),
        .Rw_EX_MEM(Rw_EX_MEM), .LD_EX_MEM(LD_EX_MEM),
        .valid_EX(valid_EX)
`ifdef PIPE_STATS_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    typedef struct {
        logic        rst, stall, flush, regwr, ld, memwr;
        logic [4:0]  rw;
        logic [31:0] a;
        logic [1:0]  opa, opb;
        logic        e_valid;
        logic [4:0]  e_rw;
        logic        e_ld;
        logic [4:0]  e_rwmem;
        logic        e_ldmem;
    } vec_t;

    typedef struct {
        logic        valid, regwr, memwr, br, alusrc, ld, ldmem;
        logic [3:0]  ctrl;
        logic [4:0]  rw, rwmem;
        logic [31:0] a, b, imm, pc, scnt, fcnt;
        logic [1:0]  opa, opb;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] es = 0, ef = 0;
    vec_t        tbl[15];

    function automatic vec_t mk(
        input logic rst, stall, flush, regwr, ld, memwr,
        input logic [4:0] rw, input logic [31:0] a,
        input logic [1:0] opa, opb,
        input logic ev, input logic [4:0] erw, input logic eld,
        input logic [4:0] erwm, input logic eldm);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush;
        v.regwr = regwr; v.ld = ld; v.memwr = memwr;
        v.rw = rw; v.a = a; v.opa = opa; v.opb = opb;
        v.e_valid = ev; v.e_rw = erw; v.e_ld = eld;
        v.e_rwmem = erwm; v.e_ldmem = eldm;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty queue");
            return;
        end
        e = sb.pop_front();
        chk("valid_EX", 32'(valid_EX), 32'(e.valid));
        chk("Rw_ID_EX", 32'(Rw_ID_EX), 32'(e.rw));
        chk("LD_ID_EX", 32'(LD_ID_EX), 32'(e.ld));
        chk("Rw_EX_MEM", 32'(Rw_EX_MEM), 32'(e.rwmem));
        chk("LD_EX_MEM", 32'(LD_EX_MEM), 32'(e.ldmem));
        chk("busA_EX", busA_EX, e.a);
        chk("busB_EX", busB_EX, e.b);
        chk("imm_EX", imm_EX, e.imm);
        chk("PC_EX", PC_EX, e.pc);
        chk("REG_WR_EX", 32'(REG_WR_EX), 32'(e.regwr));
        chk("MEM_WR_EX", 32'(MEM_WR_EX), 32'(e.memwr));
        chk("BRANCH_EX", 32'(BRANCH_EX), 32'(e.br));
        chk("ALU_SRC_EX", 32'(ALU_SRC_EX), 32'(e.alusrc));
        chk("ALU_CTRL_EX", 32'(ALU_CTRL_EX), 32'(e.ctrl));
        chk("OP_A_SEL_EX", 32'(OP_A_SEL_EX), 32'(e.opa));
        chk("OP_B_SEL_EX", 32'(OP_B_SEL_EX), 32'(e.opb));
`ifdef PIPE_STATS_EN
        chk("stall_cnt_o", stall_cnt_o, e.scnt);
        chk("flush_cnt_o", flush_cnt_o, e.fcnt);
`endif
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; Stall_ID = v.stall; Flush_EX = v.flush;
        REG_WR_ID = v.regwr; LD_ID = v.ld; MEM_WR_ID = v.memwr;
        Rw_ID = v.rw; busA_ID = v.a;
        OP_A_SEL = v.opa; OP_B_SEL = v.opb;
        busB_ID = $urandom; imm_ID = $urandom; PC_ID = $urandom;
        ALU_CTRL_ID = 4'($urandom); ALU_SRC_ID = 1'($urandom);
        BRANCH_ID = 1'($urandom);
        if (v.rst) begin
            es = 0; ef = 0;
        end else if (v.flush) ef++;
        else if (v.stall) es++;
        e.valid  = v.e_valid;
        e.rw     = v.e_rw;
        e.ld     = v.e_ld;
        e.rwmem  = v.e_rwmem;
        e.ldmem  = v.e_ldmem;
        e.a      = v.e_valid ? v.a : 32'd0;
        e.b      = v.e_valid ? busB_ID : 32'd0;
        e.imm    = v.e_valid ? imm_ID : 32'd0;
        e.pc     = v.e_valid ? PC_ID : 32'd0;
        e.regwr  = v.e_valid & v.regwr;
        e.memwr  = v.e_valid & v.memwr;
        e.br     = v.e_valid & BRANCH_ID;
        e.alusrc = v.e_valid & ALU_SRC_ID;
        e.ctrl   = v.e_valid ? ALU_CTRL_ID : 4'd0;
        e.opa    = v.e_valid ? v.opa : 2'b00;
        e.opb    = v.e_valid ? v.opb : 2'b00;
        e.scnt   = es;
        e.fcnt   = ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        vec_t       v;
        logic [4:0] m_rw;
        logic       m_ld, bub;
        reset = 1'b1; Rs_ID = 5'd1; Rt_ID = 5'd2; Rw_ID = '0;
        busA_ID = '0; busB_ID = '0; imm_ID = '0; PC_ID = '0;
        ALU_SRC_ID = 0; LD_ID = 0; REG_WR_ID = 0; MEM_WR_ID = 0;
        BRANCH_ID = 0; ALU_CTRL_ID = '0; Stall_ID = 0; Flush_EX = 0;
        OP_A_SEL = '0; OP_B_SEL = '0;

        tbl[0]  = mk(1,1,1,1,1,0, 5'd9, $urandom, 2'b01, 2'b10, 0,0,0,0,0);
        tbl[1]  = mk(1,0,0,1,0,1, 5'd9, $urandom, 2'b11, 2'b01, 0,0,0,0,0);
        tbl[2]  = mk(0,0,0,1,0,0, 5'd5, 32'h1234_5678, 2'b01, 2'b10, 1,5,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,1, 5'd7, 32'hAAAA_0000, 2'b00, 2'b00, 1,0,0,5,0);
        tbl[4]  = mk(0,0,0,1,1,0, 5'd3, 32'h3333_3333, 2'b00, 2'b00, 1,3,1,0,0);
        tbl[5]  = mk(0,1,0,1,0,0, 5'd4, 32'h4444_4444, 2'b01, 2'b00, 0,0,0,3,1);
        tbl[6]  = mk(0,0,0,1,0,0, 5'd4, 32'h4444_4444, 2'b01, 2'b00, 1,4,0,0,0);
        tbl[7]  = mk(0,1,1,1,0,0, 5'd9, 32'h9999_9999, 2'b10, 2'b10, 0,0,0,4,0);
        tbl[8]  = mk(0,0,1,1,1,0, 5'd9, 32'h9999_9999, 2'b00, 2'b00, 0,0,0,0,0);
        tbl[9]  = mk(0,1,0,0,0,0, 5'd6, 32'h6666_6666, 2'b00, 2'b00, 0,0,0,0,0);
        tbl[10] = mk(0,1,0,1,0,0, 5'd6, 32'h6666_6666, 2'b00, 2'b00, 0,0,0,0,0);
        tbl[11] = mk(0,0,0,1,0,0, 5'd6, 32'h6666_6666, 2'b00, 2'b01, 1,6,0,0,0);
        tbl[12] = mk(0,0,0,1,1,0, 5'd8, 32'h8888_8888, 2'b00, 2'b00, 1,8,1,6,0);
        tbl[13] = mk(1,1,1,1,1,0, 5'd8, 32'h8888_8888, 2'b01, 2'b01, 0,0,0,0,0);
        tbl[14] = mk(0,0,0,1,0,0, 5'd10, 32'h1234_5678, 2'b00, 2'b00, 1,10,0,0,0);

        for (int i = 0; i < 15; i++) apply(tbl[i]);

        m_rw = 5'd10;
        m_ld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.rst   = 1'b0;
            v.stall = ($urandom_range(0, 3) == 0);
            v.flush = ($urandom_range(0, 4) == 0);
            v.regwr = 1'($urandom);
            v.ld    = 1'($urandom);
            v.memwr = 1'($urandom);
            v.rw    = 5'($urandom);
            v.a     = $urandom;
            v.opa   = 2'($urandom);
            v.opb   = 2'($urandom);
            bub = v.stall | v.flush;
            v.e_valid = ~bub;
            v.e_rwmem = m_rw;
            v.e_ldmem = m_ld;
            v.e_rw    = (bub | ~v.regwr) ? 5'd0 : v.rw;
            v.e_ld    = ~bub & v.ld;
            m_rw = v.e_rw;
            m_ld = v.e_ld;
            apply(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register for the 5-stage datapath. It captures decoded operands, control and forwarding selects at the end of ID and presents them to EX. It injects bubbles on a load-use stall or branch flush and keeps the destination tags (`Rw_ID_EX`, `LD_ID_EX`, `Rw_EX_MEM`) that the hazard detector compares against. It is the direct producer of the hazard detector's EX/MEM-side inputs and the consumer of its `Stall_ID` and `OP_*_SEL` outputs.

## Interface
Parameters:
- `DATA_W`, 32: operand and immediate width.
- `PC_W`, 32: program counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `Rs_ID`, `Rt_ID`, `Rw_ID`  in  5 each  register specifiers from decode.
- `busA_ID`, `busB_ID`  in  DATA_W  register file read data.
- `imm_ID`  in  DATA_W  extended immediate.
- `PC_ID`  in  PC_W  PC+4 of the ID instruction.
- `ALU_SRC_ID`, `LD_ID`, `REG_WR_ID`, `MEM_WR_ID`, `BRANCH_ID`  in  1 each  decoded control.
- `ALU_CTRL_ID`  in  4  ALU operation.
- `Stall_ID`  in  1  load-use stall from the hazard detector.
- `OP_A_SEL`, `OP_B_SEL`  in  2 each  forwarding selects from the hazard detector.
- `Flush_EX`  in  1  branch taken, resolved in EX this cycle.
- `busA_EX`, `busB_EX`, `imm_EX`  out  DATA_W  registered operands.
- `PC_EX`  out  PC_W  registered PC+4.
- `ALU_SRC_EX`, `MEM_WR_EX`, `BRANCH_EX`, `REG_WR_EX`  out  1 each  registered control.
- `ALU_CTRL_EX`  out  4.
- `OP_A_SEL_EX`, `OP_B_SEL_EX`  out  2  registered forwarding selects.
- `Rw_ID_EX`, `LD_ID_EX`  out  5/1  EX-stage destination tag and load flag.
- `Rw_EX_MEM`, `LD_EX_MEM`  out  5/1  MEM-stage destination tag and load flag.
- `valid_EX`  out  1  EX holds a real instruction.

## Operation
- Each rising edge updates the register in exactly one of three modes:
  - **Flush**: `Flush_EX`=1. A bubble is loaded. Flush has priority over stall.
  - **Stall**: `Stall_ID`=1 and `Flush_EX`=0. A bubble is loaded. Upstream PC/IF-ID hold is handled outside this block.
  - **Advance**: all ID inputs are captured.
- **Bubble contents**:
  - All control bits are 0: `REG_WR`, `LD`, `MEM_WR`, `BRANCH`, `valid`.
  - `Rw_ID_EX`=0, `ALU_CTRL`=0, `OP_*_SEL_EX`=NO_FWD (2'b00).
  - The data fields (`busA`, `busB`, `imm`, `PC`) are also 0.
- **Tag qualification**:
  - On advance, `Rw_ID_EX` = `REG_WR_ID` ? `Rw_ID` : 0.
  - Stores and branches therefore never produce a false forwarding match.
  - A zero tag matches only `$0`, whose forwarded value is 0.
- **MEM-stage tag**:
  - `Rw_EX_MEM`/`LD_EX_MEM` capture `Rw_ID_EX`/`LD_ID_EX` every cycle, unconditionally. EX never stalls.
  - On flush, the MEM tag still takes the pre-flush EX tag. The branch instruction itself completes.
- `Rs_ID`/`Rt_ID` are used only to assert that `OP_*_SEL` is NO_FWD when the corresponding specifier is 0. This check is simulation-only and is not a functional path.
- Stall or flush with `REG_WR_ID`=0 behaves identically to stall or flush with it set.

## Timing
- Latency is one cycle from ID inputs to EX outputs. No combinational path from any input to any output.
- `Rw_EX_MEM` equals the `Rw_ID_EX` value from the previous cycle.
- **Reset**:
  - All outputs are 0 on the first edge with `reset`=1, which is the bubble state.
  - `OP_*_SEL_EX` reset to NO_FWD; `valid_EX`=0.
  - `reset` overrides flush and stall, including mid-stall. The first edge after `reset` drops is a normal mode evaluation.
- **Back-to-back stalls**: each stalled cycle inserts one bubble. The ID instruction is captured on the first edge with `Stall_ID`=0.
- **Stall and flush in the same cycle**: one bubble, and no double count in the statistics.

## Configuration
- Macro: `PIPE_STATS_EN`.
- **Defined**: adds two outputs.
  - `stall_cnt_o`: 32-bit count of stall-mode edges.
  - `flush_cnt_o`: 32-bit count of flush-mode edges.
  - Both saturate at 32'hFFFF_FFFF and clear on `reset`.
  - Flush wins over stall: a simultaneous event increments `flush_cnt_o` only.
- **Not defined**: the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset**: `reset`=1 for 2 cycles with random inputs -> every output 0 and `valid_EX`=0; the first advance after release passes `busA_ID`=32'h1234_5678 to `busA_EX` one cycle later.
- **Advance with tag qualification**: advance `add` with `Rw_ID`=5, `REG_WR_ID`=1 -> `Rw_ID_EX`=5; the next cycle `Rw_EX_MEM`=5. Advance `sw` with `Rw_ID`=7, `REG_WR_ID`=0 -> `Rw_ID_EX`=0.
- **Load-use stall**: `lw` with `Rw_ID`=3 advances, then `Stall_ID`=1 for one cycle -> EX holds a bubble (`valid_EX`=0, `LD_ID_EX`=0, `Rw_ID_EX`=0) while `Rw_EX_MEM`=3 and `LD_EX_MEM`=1; the held ID instruction appears in EX on the following cycle.
- **Flush priority**: `Flush_EX`=1 and `Stall_ID`=1 together -> a single bubble; with `PIPE_STATS_EN` defined, `flush_cnt_o` increments by 1 and `stall_cnt_o` is unchanged.
- **Forwarding selects**: advance with `OP_A_SEL`=2'b01, `OP_B_SEL`=2'b10 -> both appear unchanged on `OP_*_SEL_EX` next cycle; a bubble forces both to 2'b00.
- **Reset mid-stall**: `reset` asserted in the same cycle as `Stall_ID`=1 and `Flush_EX`=1 -> all outputs 0 and counters 0.
